// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared widths, FSM states and saturation helper for the k-means divider stage
package kmeans_pkg;
  localparam int centroid_num = 8;
  localparam int coord_num = 7;
  localparam int accum_cord_width = 22;
  localparam int accum_width = coord_num * accum_cord_width;
  localparam int cordinate_width = 13;
  localparam int dataWidth = coord_num * cordinate_width;
  localparam int count_width = 10;
  localparam int idx_width = 3;
  localparam int DIV_CYCLES = 22;
  localparam logic [cordinate_width-1:0] SAT_MAX = 13'h0FFF;
  localparam logic [cordinate_width-1:0] SAT_MIN = 13'h1000;
  typedef enum logic [2:0] {IDLE, LOAD, DIV, EMIT, FIN} state_t;
  // Clamp an unsigned quotient magnitude with sign into the 13-bit signed range
  function automatic logic [cordinate_width-1:0] sat_coord(input logic neg, input logic [accum_cord_width-1:0] mag);
    return neg ? ((mag > 22'd4096) ? SAT_MIN : 13'(-mag[cordinate_width-1:0]))
               : ((mag > 22'd4095) ? SAT_MAX : mag[cordinate_width-1:0]);
  endfunction
endpackage

// File: rtl/mean_div_lane.sv
// mean_div_lane: one signed-sum by unsigned-count restoring divider, one quotient bit per step
module mean_div_lane
  import kmeans_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load,
  input  logic                        i_step,
  input  logic                        i_last,
  input  logic [accum_cord_width-1:0] i_sum,
  input  logic [count_width-1:0]      i_count,
  output logic [cordinate_width-1:0]  o_q
);
  logic [accum_cord_width-1:0] r_dq;
  logic [count_width:0]        r_rem;
  logic [count_width-1:0]      r_div;
  logic                        r_neg;
  logic [count_width+1:0]      w_t;
  logic                        w_ge;
  logic [accum_cord_width-1:0] w_dq;
  assign w_t  = {r_rem, r_dq[accum_cord_width-1]};
  assign w_ge = w_t >= {2'b00, r_div};
  assign w_dq = {r_dq[accum_cord_width-2:0], w_ge};
  // Dividend register shifts out magnitude bits and shifts in quotient bits; sign applied on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dq  <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_neg <= 1'b0;
      o_q   <= '0;
    end else if (i_load) begin
      r_dq  <= i_sum[accum_cord_width-1] ? -i_sum : i_sum;
      r_neg <= i_sum[accum_cord_width-1];
      r_div <= i_count;
      r_rem <= '0;
      o_q   <= '0;
    end else if (i_step) begin
      r_dq  <= w_dq;
      r_rem <= w_ge ? 11'(w_t - {2'b00, r_div}) : w_t[count_width:0];
      if (i_last) o_q <= sat_coord(r_neg, w_dq);
    end
  end
endmodule

// File: rtl/new_means_divider.sv
// new_means_divider: walks all centroids, divides accumulated sums by counts and emits new centroids
module new_means_divider
  import kmeans_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [idx_width-1:0]   acc_rd_idx,
  input  logic [accum_width-1:0] accum_in,
  input  logic [count_width-1:0] count_in,
  output logic [dataWidth-1:0]   new_centroid_in,
  output logic [idx_width-1:0]   cent_num,
  output logic                   divide_by_0,
  output logic                   centroid_valid,
  output logic                   busy,
  output logic                   done
);
  state_t                 r_state, w_next;
  logic [4:0]             r_cnt;
  logic [idx_width-1:0]   r_idx;
  logic                   r_dz;
  logic                   w_last;
  logic [dataWidth-1:0]   w_q;
  assign acc_rd_idx = r_idx;
  assign w_last = r_cnt == 5'(DIV_CYCLES - 1);
  for (genvar i = 0; i < coord_num; i++) begin : g_lane
    mean_div_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (r_state == LOAD),
      .i_step  (r_state == DIV),
      .i_last  (w_last),
      .i_sum   (accum_in[i*accum_cord_width +: accum_cord_width]),
      .i_count (count_in),
      .o_q     (w_q[i*cordinate_width +: cordinate_width])
    );
  end
  // Next-state selection for the per-centroid load/divide/emit sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? LOAD : IDLE;
      LOAD:    w_next = (count_in == '0) ? EMIT : DIV;
      DIV:     w_next = w_last ? EMIT : DIV;
      EMIT:    w_next = (r_idx == idx_width'(centroid_num - 1)) ? FIN : LOAD;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // State register, index/step counters and held output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_dz            <= 1'b0;
      new_centroid_in <= '0;
      cent_num        <= '0;
      divide_by_0     <= 1'b0;
      centroid_valid  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cnt          <= (r_state == DIV) ? r_cnt + 5'd1 : '0;
      centroid_valid <= r_state == EMIT;
      done           <= r_state == FIN;
      busy           <= w_next != IDLE;
      if (r_state == IDLE && start) r_idx <= '0;
      if (r_state == LOAD) r_dz <= count_in == '0;
      if (r_state == EMIT) begin
        new_centroid_in <= w_q;
        cent_num        <= r_idx;
        divide_by_0     <= r_dz;
        if (r_idx != idx_width'(centroid_num - 1)) r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_new_means_divider.sv
// tb_new_means_divider: randomized passes checked against an arithmetic model of the divider stage
module tb_new_means_divider;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   acc_rd_idx;
  logic [153:0] accum_in;
  logic [9:0]   count_in;
  logic [90:0]  new_centroid_in;
  logic [2:0]   cent_num;
  logic         divide_by_0, centroid_valid, busy, done;
  logic [21:0]  sums [8][7];
  logic [9:0]   cnts [8];
  logic [90:0]  h_data, cap [8];
  logic [2:0]   h_idx;
  logic         h_dz, capdz [8];
  int tests = 0;
  int fails = 0;

  new_means_divider dut (
    .clk(clk), .rst(rst), .start(start), .acc_rd_idx(acc_rd_idx), .accum_in(accum_in),
    .count_in(count_in), .new_centroid_in(new_centroid_in), .cent_num(cent_num),
    .divide_by_0(divide_by_0), .centroid_valid(centroid_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    accum_in = '0;
    for (int j = 0; j < 7; j++) accum_in[j*22 +: 22] = sums[acc_rd_idx][j];
    count_in = cnts[acc_rd_idx];
  end

  function automatic logic [12:0] eq(input logic [21:0] s, input logic [9:0] c);
    int sv, q;
    logic [31:0] qb;
    if (c == 0) return 13'd0;
    sv = $signed(s);
    q = sv / int'(c);
    if (q > 4095) q = 4095;
    if (q < -4096) q = -4096;
    qb = q;
    return qb[12:0];
  endfunction

  function automatic logic [90:0] ew(input int k);
    logic [90:0] w;
    w = '0;
    for (int j = 0; j < 7; j++) w[j*13 +: 13] = eq(sums[k][j], cnts[k]);
    return w;
  endfunction

  task automatic chk(input string name, input logic [90:0] act, input logic [90:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " idx"}, 91'(acc_rd_idx), 91'd0);
    chk({tag, " data"}, new_centroid_in, 91'd0);
    chk({tag, " cent_num"}, 91'(cent_num), 91'd0);
    chk({tag, " dz"}, 91'(divide_by_0), 91'd0);
    chk({tag, " valid"}, 91'(centroid_valid), 91'd0);
    chk({tag, " busy"}, 91'(busy), 91'd0);
    chk({tag, " done"}, 91'(done), 91'd0);
  endtask

  task automatic run_pass(input int spur_at, input int rst_at);
    int tv [8];
    int t, td, k, nv;
    logic ev;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      t += (cnts[i] == 0) ? 2 : 24;
      tv[i] = t;
    end
    td = t + 1;
    k = 0;
    nv = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c <= td + 2; c++) begin
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("mid-pass reset");
        h_data = '0;
        h_idx = '0;
        h_dz = 1'b0;
        return;
      end
      start = (c == spur_at);
      ev = (k < 8) && (c == tv[k]);
      chk("centroid_valid", 91'(centroid_valid), 91'(ev));
      if (centroid_valid) nv++;
      if (ev) begin
        h_data = ew(k);
        h_idx = 3'(k);
        h_dz = cnts[k] == 0;
        cap[k] = new_centroid_in;
        capdz[k] = divide_by_0;
        k++;
      end
      chk("new_centroid_in", new_centroid_in, h_data);
      chk("cent_num", 91'(cent_num), 91'(h_idx));
      chk("divide_by_0", 91'(divide_by_0), 91'(h_dz));
      chk("done", 91'(done), 91'(c == td));
      chk("busy", 91'(busy), 91'(c < td));
      @(negedge clk);
    end
    start = 1'b0;
    chk("valid pulse count", 91'(nv), 91'd8);
  endtask

  task automatic rand_tables(input bit allow_zero);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 7; j++) begin
        r = $urandom;
        sums[i][j] = r[21:0];
      end
      if (allow_zero && $urandom_range(0, 5) == 0) cnts[i] = 10'd0;
      else cnts[i] = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(1, 8)) : 10'($urandom_range(1, 1023));
    end
  endtask

  initial begin
    h_data = '0;
    h_idx = '0;
    h_dz = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cnts[i] = 10'd1;
      for (int j = 0; j < 7; j++) sums[i][j] = '0;
    end
    chk("model 300/3", 91'(eq(22'd300, 10'd3)), 91'(13'd100));
    chk("model -7/2", 91'(eq(-22'sd7, 10'd2)), 91'(13'h1FFD));
    chk("model 7/2", 91'(eq(22'd7, 10'd2)), 91'(13'd3));
    chk("model -1/5", 91'(eq(-22'sd1, 10'd5)), 91'(13'd0));
    chk("model sat hi", 91'(eq(22'h1FFFFF, 10'd1)), 91'(13'h0FFF));
    chk("model sat lo", 91'(eq(22'h200000, 10'd1)), 91'(13'h1000));
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    sums[0][0] = 22'd300;
    cnts[0] = 10'd3;
    sums[1][0] = -22'sd7;
    sums[1][1] = 22'd7;
    cnts[1] = 10'd2;
    sums[2][0] = -22'sd1;
    cnts[2] = 10'd5;
    sums[3][0] = 22'd1234;
    cnts[3] = 10'd0;
    sums[4][0] = 22'h1FFFFF;
    sums[4][1] = 22'h200000;
    cnts[4] = 10'd1;
    run_pass(50, -1);
    chk("c0 coord0", 91'(cap[0][12:0]), 91'(13'd100));
    chk("c0 others", 91'(cap[0][90:13]), 91'd0);
    chk("c1 coord0", 91'(cap[1][12:0]), 91'(13'h1FFD));
    chk("c1 coord1", 91'(cap[1][25:13]), 91'(13'd3));
    chk("c2 coord0", 91'(cap[2][12:0]), 91'(13'd0));
    chk("c3 data", cap[3], 91'd0);
    chk("c3 dz", 91'(capdz[3]), 91'd1);
    chk("c4 coord0", 91'(cap[4][12:0]), 91'(13'h0FFF));
    chk("c4 coord1", 91'(cap[4][25:13]), 91'(13'h1000));
    rand_tables(1'b0);
    run_pass(-1, 130);
    @(negedge clk);
    rand_tables(1'b0);
    run_pass(100, -1);
    for (int p = 0; p < 3; p++) begin
      rand_tables(1'b1);
      run_pass(-1, -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
